bch_syndrome_multi_method1: RTL and testbench
=============================================

# bch_syndrome_multi_method1

Multi-syndrome, multi-bit-per-cycle Horner-method syndrome calculator with framing and an output handshake. It accepts a BCH codeword as a stream of BITS-wide words, computes the odd syndromes S_1, S_3, …, S_(2·NSYN−1) in parallel, and presents them as one registered bundle under valid/ready flow control. It sits between the receive data path and the error-locator stage, replacing per-syndrome instances that the caller sequenced by hand.

## Interface
- P, `BCH_SANE: BCH parameter vector; M = `BCH_M(P).
- NSYN, 2: number of syndromes; syndrome k (0-based) is S_(2k+1).
- BITS, 1: codeword bits accepted per input word (1..16).
- CW_BITS, 255: transmitted codeword length in bits; WORDS = ceil(CW_BITS/BITS).
- PIPELINE_STAGES, 0: register stages after the term adder (0 or 1; 2+ is an elaboration error).

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  first word of a frame; qualified by ce && in_ready
- ce  in  1  data_in valid
- data_in  in  BITS  codeword bits; data_in[BITS−1] is earliest (highest degree)
- in_ready  out  1  word is accepted when ce && in_ready
- syn_valid  out  1  syn_out holds a completed frame
- syn_ready  in  1  downstream accepts syn_out
- syn_out  out  NSYN·M  syndrome k at [k·M +: M]
- err_present  out  1  any syndrome nonzero (see Configuration)
- busy  out  1  frame in progress or results pending

## Operation
- States: IDLE, ACCUM, FLUSH (PIPELINE_STAGES=1 only), DONE.
- IDLE: in_ready=1; ce without start is ignored; ce && start → ACCUM, word count = 1.
- Horner per syndrome j: acc ← acc·α^(j·BITS) ⊕ Σ_i data_in[i]·α^(j·i), all GF(2^M) with constant multipliers; the start word loads the term sum with acc treated as 0.
- First word of a frame: only the low R = CW_BITS − (WORDS−1)·BITS bits are used; upper BITS−R bits are masked to 0 (front padding keeps Horner exact, no end correction).
- Word counter 0..WORDS−1; on accepting word WORDS−1 → FLUSH (PIPELINE_STAGES=1) or DONE.
- DONE: syn_out and syn_valid registered; syn_out stable while syn_valid && !syn_ready.
- in_ready = 0 in FLUSH and in DONE unless syn_ready=1 the same cycle; DONE && syn_valid && syn_ready && ce && start accepts the next frame's first word (back-to-back, zero bubble).
- DONE && syn_ready with no new start → IDLE, syn_valid cleared.
- start accepted in ACCUM: current frame aborted without output, new frame begins with this word as word 0.
- ce without start in ACCUM: normal word; ce low: accumulator and counter hold.
- busy = state != IDLE.

## Timing
- Reset (async): state IDLE, accumulators 0, counter 0, syn_out 0, syn_valid 0, err_present 0, busy 0; in_ready 1 after reset deasserts.
- Latency, last word accepted → syn_valid: 1 cycle (PIPELINE_STAGES=0), 2 cycles (1).
- Throughput: one word per cycle; a frame occupies WORDS input cycles, plus 1 (FLUSH) when pipelined.
- Reset mid-frame discards all partial state; no syn_valid for that frame.
- The pipeline register advances only on accepted words; FLUSH drains it unconditionally in one cycle.

## Configuration
- BCH_SYN_ERR_FLAG_EN defined: err_present = OR of all NSYN·M syndrome bits, registered with syn_out, valid while syn_valid.
- Undefined: err_present tied 0, OR-reduction not built.

## Test plan
- NSYN=2, M=8, BITS=1, all-zero 255-bit frame → after 255 words + 1 cycle, syn_valid=1, syn_out=0, err_present=0.
- Same, only the last bit (r_0) set → S_1 = S_3 = 1, err_present=1 (with BCH_SYN_ERR_FLAG_EN).
- BITS=4, CW_BITS=255 (R=3), r_1 set, data_in[3] of the first word forced 1 → S_j = α^j; masked bit has no effect.
- syn_ready held low 5 cycles in DONE → syn_out stable, in_ready=0, next frame's start word accepted in the cycle syn_ready rises, no bubble.
- start reasserted at word 100 → first frame yields no output; syndromes match the second frame alone.
- reset pulsed at word 50, PIPELINE_STAGES=1 → all outputs at reset values immediately; next full frame is correct with 2-cycle latency.

Source files
------------

// File: rtl/bch_syndrome_multi_method1.sv
// rtl/bch_syndrome_multi_method1.sv - multi-syndrome, multi-bit Horner BCH syndrome calculator
//
// Computes the odd syndromes S_1, S_3, ..., S_(2*NSYN-1) of a BCH codeword that arrives as
// BITS-wide words, highest degree first. The results are presented as one registered bundle
// under valid/ready flow control.
// Optional feature macro: BCH_SYN_ERR_FLAG_EN (registered OR of all syndrome bits on err_present).
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   start        first word of a frame, qualified by ce && in_ready
//   ce           data_in valid
//   data_in      codeword bits, data_in[BITS-1] is earliest (highest degree)
//   in_ready     word accepted when ce && in_ready
//   syn_valid    syn_out holds a completed frame
//   syn_ready    downstream accepts syn_out
//   syn_out      syndrome k (S_(2k+1)) at [k*M +: M]
//   err_present  any syndrome nonzero (0 when the flag feature is not built)
//   busy         frame in progress or results pending
module bch_syndrome_multi_method1 #(
  parameter int          M               = 8,
  parameter int unsigned PRIM_POLY       = 'h11d,
  parameter int          NSYN            = 2,
  parameter int          BITS            = 1,
  parameter int          CW_BITS         = 255,
  parameter int          PIPELINE_STAGES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ce,
  input  logic [BITS-1:0]      data_in,
  output logic                 in_ready,
  output logic                 syn_valid,
  input  logic                 syn_ready,
  output logic [NSYN*M-1:0]    syn_out,
  output logic                 err_present,
  output logic                 busy
);

  localparam int WORDS = (CW_BITS + BITS - 1) / BITS;
  localparam int R     = CW_BITS - (WORDS - 1) * BITS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WORDS - 1);
  // Front padding of the first word: only its low R bits belong to the codeword.
  localparam logic [BITS-1:0]  FIRST_MASK = BITS'((64'd1 << R) - 64'd1);
  localparam logic             PIPE       = (PIPELINE_STAGES == 1);

  if (PIPELINE_STAGES > 1) begin : g_bad_stages
    $error("PIPELINE_STAGES must be 0 or 1");
  end

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] r;
    r = M'(1);
    for (int n = 0; n < e; n++) r = mul_alpha(r);
    alpha_pow = r;
  endfunction

  // Second operand is always an elaboration constant, so this folds to an XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = mul_alpha(r);
      if (b[i]) r = r ^ a;
    end
    gf_mul = r;
  endfunction

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NSYN*M-1:0]   acc_q, acc_d;
  logic [NSYN*M-1:0]   pipe_q, pipe_d;
  logic                pipe_load_q, pipe_load_d;
  logic                pipe_valid_q, pipe_valid_d;
  logic [NSYN*M-1:0]   syn_q, syn_d;
  logic                syn_valid_q, syn_valid_d;

  logic                accept, new_frame, word_in, is_last, load_out, load_sel;
  logic [BITS-1:0]     data_m;
  logic [NSYN*M-1:0]   term, add_sel, acc_applied;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM) || ((state_q == DONE) && syn_ready);
  assign accept    = ce && in_ready;
  assign new_frame = accept && start;
  // Non-start words outside ACCUM are accepted but dropped.
  assign word_in   = new_frame || (accept && (state_q == ACCUM));
  assign is_last   = word_in && ((new_frame ? '0 : cnt_q) == LAST_CNT);
  assign data_m    = start ? (data_in & FIRST_MASK) : data_in;

  // With the pipeline the term being folded in is the registered one from the previous word.
  assign add_sel   = PIPE ? pipe_q : term;
  assign load_sel  = PIPE ? pipe_load_q : start;

  for (genvar k = 0; k < NSYN; k++) begin : g_syn
    localparam int           J    = 2 * k + 1;
    localparam logic [M-1:0] STEP = alpha_pow(J * BITS);
    logic [M-1:0] t;
    always_comb begin
      t = '0;
      for (int i = 0; i < BITS; i++) begin
        if (data_m[i]) t = t ^ alpha_pow(J * i);
      end
    end
    assign term[k*M +: M]        = t;
    assign acc_applied[k*M +: M] = load_sel ? add_sel[k*M +: M]
                                            : (gf_mul(acc_q[k*M +: M], STEP) ^ add_sel[k*M +: M]);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    pipe_d       = pipe_q;
    pipe_load_d  = pipe_load_q;
    pipe_valid_d = pipe_valid_q;
    syn_d        = syn_q;
    load_out     = 1'b0;

    if (PIPE) begin
      if (word_in) begin
        if (pipe_valid_q) acc_d = acc_applied;
        pipe_d       = term;
        pipe_load_d  = start;
        pipe_valid_d = 1'b1;
      end else if (state_q == FLUSH) begin
        if (pipe_valid_q) acc_d = acc_applied;
        pipe_valid_d = 1'b0;
        load_out     = 1'b1;
      end
    end else begin
      if (word_in) acc_d = acc_applied;
      if (is_last) load_out = 1'b1;
    end

    if (word_in) cnt_d = new_frame ? CNT_W'(1) : cnt_q + CNT_W'(1);
    if (is_last) cnt_d = '0;

    if (is_last)                            state_d = PIPE ? FLUSH : DONE;
    else if (word_in)                       state_d = ACCUM;
    else if (state_q == FLUSH)              state_d = DONE;
    else if (state_q == DONE && syn_ready)  state_d = IDLE;

    if (load_out) syn_d = acc_d;
    syn_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      pipe_q       <= '0;
      pipe_load_q  <= 1'b0;
      pipe_valid_q <= 1'b0;
      syn_q        <= '0;
      syn_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      pipe_q       <= pipe_d;
      pipe_load_q  <= pipe_load_d;
      pipe_valid_q <= pipe_valid_d;
      syn_q        <= syn_d;
      syn_valid_q  <= syn_valid_d;
    end
  end

`ifdef BCH_SYN_ERR_FLAG_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (load_out) err_d = |syn_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err_present = err_q;
`else
  assign err_present = 1'b0;
`endif

  assign syn_out   = syn_q;
  assign syn_valid = syn_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bch_syndrome_multi_method1.sv
// tb/tb_bch_syndrome_multi_method1.sv - scoreboard bench for bch_syndrome_multi_method1
module tb_bch_syndrome_multi_method1;

  typedef struct { logic [15:0] syn; logic err; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BITS=1, no pipeline. Instance B: BITS=4 (R=3), pipelined.
  logic        rst_a, start_a, ce_a, din_a, in_ready_a, syn_valid_a, syn_ready_a, err_a, busy_a;
  logic [15:0] syn_out_a;
  logic        rst_b, start_b, ce_b, in_ready_b, syn_valid_b, syn_ready_b, err_b, busy_b;
  logic [3:0]  din_b;
  logic [15:0] syn_out_b;

  bch_syndrome_multi_method1 #(.NSYN(2), .BITS(1), .CW_BITS(255), .PIPELINE_STAGES(0)) u_a (
    .clk(clk), .reset(rst_a), .start(start_a), .ce(ce_a), .data_in(din_a),
    .in_ready(in_ready_a), .syn_valid(syn_valid_a), .syn_ready(syn_ready_a),
    .syn_out(syn_out_a), .err_present(err_a), .busy(busy_a));

  bch_syndrome_multi_method1 #(.NSYN(2), .BITS(4), .CW_BITS(255), .PIPELINE_STAGES(1)) u_b (
    .clk(clk), .reset(rst_b), .start(start_b), .ce(ce_b), .data_in(din_b),
    .in_ready(in_ready_b), .syn_valid(syn_valid_b), .syn_ready(syn_ready_b),
    .syn_out(syn_out_b), .err_present(err_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] alog [0:254];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Direct evaluation S_j = sum r_i * alpha^(j*i) over GF(2^8), poly x^8+x^4+x^3+x^2+1.
  function automatic exp_t model(input logic [254:0] cw);
    exp_t e;
    e.syn = '0;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < 255; i++) if (cw[i]) s = s ^ alog[((2 * k + 1) * i) % 255];
      e.syn[k*8 +: 8] = s;
    end
`ifdef BCH_SYN_ERR_FLAG_EN
    e.err = (e.syn != 16'd0);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [254:0] rand_cw();
    logic [254:0] c;
    for (int i = 0; i < 255; i++) c[i] = 1'($urandom_range(0, 1));
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst_a && syn_valid_a && syn_ready_a) begin
      if (q_a.size() == 0) check_eq("a_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check_eq("a_syn_out", {16'd0, syn_out_a}, {16'd0, e.syn});
        check_eq("a_err_present", {31'd0, err_a}, {31'd0, e.err});
      end
    end
    if (!rst_b && syn_valid_b && syn_ready_b) begin
      if (q_b.size() == 0) check_eq("b_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check_eq("b_syn_out", {16'd0, syn_out_b}, {16'd0, e.syn});
        check_eq("b_err_present", {31'd0, err_b}, {31'd0, e.err});
      end
    end
  end

  // Word tasks start and end at posedge+1; acceptance is judged at the negedge before the edge.
  task automatic word_a(input logic st, input logic d);
    int g = 0;
    ce_a = 1'b1; start_a = st; din_a = d;
    @(negedge clk);
    while (!in_ready_a && g < 20) begin @(negedge clk); g++; end
    if (!in_ready_a) check_eq("a_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic word_b(input logic st, input logic [3:0] d);
    int g = 0;
    ce_b = 1'b1; start_b = st; din_b = d;
    @(negedge clk);
    while (!in_ready_b && g < 20) begin @(negedge clk); g++; end
    if (!in_ready_b) check_eq("b_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [254:0] cw, input int first, input int nw);
    for (int w = first; w < nw; w++) word_a(w == 0, cw[254 - w]);
  endtask

  task automatic send_b(input logic [255:0] ext, input int nw);
    for (int w = 0; w < nw; w++) word_b(w == 0, ext[(63 - w) * 4 +: 4]);
  endtask

  task automatic wait_valid_a(input int exp_lat);
    int n = 1;
    ce_a = 1'b0; start_a = 1'b0;
    @(negedge clk);
    while (!syn_valid_a && n < 8) begin @(negedge clk); n++; end
    check_eq("a_latency", n, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid_b(input int exp_lat);
    int n = 1;
    ce_b = 1'b0; start_b = 1'b0;
    @(negedge clk);
    check_eq("b_flush_in_ready", {31'd0, in_ready_b}, 32'd0);
    while (!syn_valid_b && n < 8) begin @(negedge clk); n++; end
    check_eq("b_latency", n, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [254:0] cw, cw2;
    logic [255:0] ext;
    exp_t e;

    alog[0] = 8'd1;
    for (int i = 1; i < 255; i++) alog[i] = {alog[i-1][6:0], 1'b0} ^ (alog[i-1][7] ? 8'h1d : 8'h00);

    rst_a = 1'b1; rst_b = 1'b1;
    ce_a = 0; start_a = 0; din_a = 0; syn_ready_a = 1;
    ce_b = 0; start_b = 0; din_b = 0; syn_ready_b = 1;
    #1;
    check_eq("rst_a_syn_valid", {31'd0, syn_valid_a}, 32'd0);
    check_eq("rst_a_syn_out", {16'd0, syn_out_a}, 32'd0);
    check_eq("rst_a_err", {31'd0, err_a}, 32'd0);
    check_eq("rst_a_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_b_busy", {31'd0, busy_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_eq("a_in_ready_after_reset", {31'd0, in_ready_a}, 32'd1);
    check_eq("b_in_ready_after_reset", {31'd0, in_ready_b}, 32'd1);
    @(posedge clk); #1;

    // ce without start in IDLE is ignored.
    ce_a = 1'b1; din_a = 1'b1;
    repeat (3) @(posedge clk);
    #1; ce_a = 1'b0;
    check_eq("a_idle_ce_ignored_busy", {31'd0, busy_a}, 32'd0);

    // All-zero frame, then only r_0 set.
    cw = '0;         q_a.push_back(model(cw)); send_a(cw, 0, 255); wait_valid_a(1);
    cw = 255'd1;     q_a.push_back(model(cw)); send_a(cw, 0, 255); wait_valid_a(1);
    e = model(cw);
    check_eq("model_r0_syn", {16'd0, e.syn}, 32'h0101);
    for (int f = 0; f < 2; f++) begin
      cw = rand_cw(); q_a.push_back(model(cw)); send_a(cw, 0, 255); wait_valid_a(1);
    end

    // Abort: start reasserted at word 100; only the second frame yields a result.
    cw = rand_cw(); cw2 = rand_cw();
    send_a(cw, 0, 100);
    q_a.push_back(model(cw2)); send_a(cw2, 0, 255); wait_valid_a(1);

    // Stall in DONE for several cycles, then back-to-back start in the cycle ready rises.
    cw = rand_cw(); cw2 = rand_cw();
    syn_ready_a = 1'b0;
    q_a.push_back(model(cw)); send_a(cw, 0, 255); wait_valid_a(1);
    e = model(cw);
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_syn_out", {16'd0, syn_out_a}, {16'd0, e.syn});
      check_eq("stall_syn_valid", {31'd0, syn_valid_a}, 32'd1);
      check_eq("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
    end
    @(posedge clk); #1;
    syn_ready_a = 1'b1;
    q_a.push_back(model(cw2));
    word_a(1'b1, cw2[254]);
    check_eq("b2b_busy", {31'd0, busy_a}, 32'd1);
    check_eq("b2b_syn_valid_cleared", {31'd0, syn_valid_a}, 32'd0);
    send_a(cw2, 1, 255); wait_valid_a(1);

    // BITS=4: r_1 set, masked pad bit forced to 1 -> S_j = alpha^j.
    cw = 255'd2; ext = {1'b1, cw};
    q_b.push_back(model(cw));
    e = model(cw);
    check_eq("model_r1_syn", {16'd0, e.syn}, 32'h0802);
    send_b(ext, 64); wait_valid_b(2);
    for (int f = 0; f < 3; f++) begin
      cw = rand_cw(); ext = {1'($urandom_range(0, 1)), cw};
      q_b.push_back(model(cw)); send_b(ext, 64); wait_valid_b(2);
    end

    // Reset mid-frame on the pipelined instance (word 50 of the frame).
    cw = rand_cw(); ext = {1'b0, cw};
    send_b(ext, 50);
    ce_b = 1'b0; start_b = 1'b0;
    rst_b = 1'b1; #1;
    check_eq("midrst_syn_valid", {31'd0, syn_valid_b}, 32'd0);
    check_eq("midrst_syn_out", {16'd0, syn_out_b}, 32'd0);
    check_eq("midrst_err", {31'd0, err_b}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1; rst_b = 1'b0;
    check_eq("midrst_in_ready", {31'd0, in_ready_b}, 32'd1);
    cw = rand_cw(); ext = {1'b1, cw};
    q_b.push_back(model(cw)); send_b(ext, 64); wait_valid_b(2);

    repeat (4) @(posedge clk);
    check_eq("a_queue_drained", q_a.size(), 32'd0);
    check_eq("b_queue_drained", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
